// File: rtl/phase_sequencer_if.sv
// Handshake and display bundle for phase_sequencer.
// The sequencer uses the slave modport and the switch wrapper or bench uses master.
interface phase_sequencer_if;
  logic       start;
  logic       advance;
  logic       abort;
  logic [2:0] phase;
  logic [7:0] led_code;
  logic [7:0] step_cnt;
  logic       tick;
  logic       busy;
  logic       done;

  modport master (
    output start, advance, abort,
    input  phase, led_code, step_cnt, tick, busy, done
  );

  modport slave (
    input  start, advance, abort,
    output phase, led_code, step_cnt, tick, busy, done
  );
endinterface

// File: rtl/phase_sequencer.sv
// Tick-paced IDLE/COUNT/WAIT/DONE display sequencer with a start/advance/abort handshake.
// Define PHASE_SEQ_AUTO_RESTART_EN to make DONE return to COUNT on its first tick.
module phase_sequencer #(
  parameter logic [23:0] PRESCALE    = 24'd10_000_000,
  parameter logic [7:0]  COUNT_STEPS = 8'd4,
  parameter logic [7:0]  WAIT_TICKS  = 8'd8
) (
  input logic              clk,
  input logic              reset,
  phase_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3
  } phase_e;

  phase_e      state_q, state_d;
  logic [23:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]  step_q, step_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  led_q, led_d;
  logic        done_q, done_d;
  logic        tick;
  logic        entering_count;

  assign tick = (pre_cnt_q == PRESCALE - 24'd1) && (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pre_cnt_q <= '0;
      step_q    <= '0;
      wait_q    <= '0;
      led_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      step_q    <= step_d;
      wait_q    <= wait_d;
      led_q     <= led_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (bus.start) state_d = COUNT;
        COUNT: if (tick && step_q == COUNT_STEPS - 8'd1) state_d = WAIT;
        WAIT:  if (bus.advance || (tick && wait_q == WAIT_TICKS - 8'd1)) state_d = DONE;
        DONE: begin
          if (bus.advance) state_d = IDLE;
`ifdef PHASE_SEQ_AUTO_RESTART_EN
          else if (tick) state_d = COUNT;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Counter and display values are computed from the next phase so the
  // registered outputs line up with the phase register on the same edge.
  always_comb begin
    entering_count = (state_d == COUNT) && (state_q != COUNT);

    if (state_d == IDLE || entering_count)
      pre_cnt_d = '0;
    else if (pre_cnt_q == PRESCALE - 24'd1)
      pre_cnt_d = '0;
    else
      pre_cnt_d = pre_cnt_q + 24'd1;

    if (state_d == IDLE || entering_count)
      step_d = '0;
    else if (state_q == COUNT && tick)
      step_d = step_q + 8'd1;
    else
      step_d = step_q;

    if (state_q == WAIT && state_d == WAIT)
      wait_d = tick ? wait_q + 8'd1 : wait_q;
    else
      wait_d = '0;

    case (state_d)
      IDLE:    led_d = 8'h00;
      COUNT:   led_d = 8'h0A;
      WAIT:    led_d = 8'h05;
      DONE:    led_d = 8'h0F;
      default: led_d = 8'h11;
    endcase
    if (!(state_q inside {IDLE, COUNT, WAIT, DONE}))
      led_d = 8'h11;

    done_d = (state_d == DONE) && (state_q != DONE);
  end

  assign bus.phase    = state_q;
  assign bus.led_code = led_q;
  assign bus.step_cnt = step_q;
  assign bus.tick     = tick;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed table, corner sequences and
// randomized traffic compared against a tick-age reference model.
module tb_phase_sequencer;
  localparam int P  = 4;
  localparam int CS = 3;
  localparam int WT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  phase_sequencer_if bus ();

  phase_sequencer #(
    .PRESCALE   (24'd4),
    .COUNT_STEPS(8'd3),
    .WAIT_TICKS (8'd2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: ticks derived from cycles elapsed since the last COUNT entry
  int m_phase, m_age, m_steps, m_waits;
  bit m_done;

  typedef struct {
    bit s, a, ab;
    int ph, led, step, tk, dn;
  } vec_t;
  vec_t tbl[23];

  function automatic vec_t mk(bit s, bit a, bit ab, int ph, int led, int step, int tk, int dn);
    vec_t v;
    v.s = s; v.a = a; v.ab = ab; v.ph = ph; v.led = led; v.step = step; v.tk = tk; v.dn = dn;
    return v;
  endfunction

  task automatic check(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, actual, expected);
    end
  endtask

  function automatic int led_of(int p);
    case (p)
      1: return 32'h0A;
      2: return 32'h05;
      3: return 32'h0F;
      default: return 32'h00;
    endcase
  endfunction

  function automatic bit m_tick();
    return (m_phase != 0) && ((m_age % P) == P - 1);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_steps = 0; m_waits = 0; m_done = 0;
  endtask

  task automatic model_step(bit s, bit a, bit ab);
    bit t;
    t = m_tick();
    m_done = 0;
    if (ab) begin
      m_phase = 0; m_age = 0; m_steps = 0; m_waits = 0;
    end else begin
      case (m_phase)
        0: begin
          m_age = 0;
          if (s) begin m_phase = 1; m_steps = 0; end
        end
        1: begin
          m_age++;
          if (t) begin
            m_steps++;
            if (m_steps == CS) begin m_phase = 2; m_waits = 0; end
          end
        end
        2: begin
          m_age++;
          if (t) m_waits++;
          if (a || (t && m_waits == WT)) begin m_phase = 3; m_done = 1; end
        end
        default: begin
          if (a) begin
            m_phase = 0; m_age = 0; m_steps = 0;
          end
`ifdef PHASE_SEQ_AUTO_RESTART_EN
          else if (t) begin
            m_phase = 1; m_age = 0; m_steps = 0;
          end
`endif
          else m_age++;
        end
      endcase
    end
  endtask

  task automatic compare_model();
    check("model_phase", int'(bus.phase),    m_phase);
    check("model_led",   int'(bus.led_code), led_of(m_phase));
    check("model_step",  int'(bus.step_cnt), m_steps);
    check("model_tick",  int'(bus.tick),     int'(m_tick()));
    check("model_busy",  int'(bus.busy),     int'(m_phase != 0));
    check("model_done",  int'(bus.done),     int'(m_done));
  endtask

  task automatic cycle(bit s, bit a, bit ab);
    bus.start = s; bus.advance = a; bus.abort = ab;
    @(posedge clk);
    model_step(s, a, ab);
    cyc++;
    #1;
    compare_model();
  endtask

  task automatic run_until(int target, int max_cycles);
    int n = 0;
    while (int'(bus.phase) != target && n < max_cycles) begin
      cycle(1'b0, 1'b0, 1'b0);
      n++;
    end
    check("reach_phase", int'(bus.phase), target);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_phase"}, int'(bus.phase),    0);
    check({tag, "_led"},   int'(bus.led_code), 0);
    check({tag, "_step"},  int'(bus.step_cnt), 0);
    check({tag, "_tick"},  int'(bus.tick),     0);
    check({tag, "_busy"},  int'(bus.busy),     0);
    check({tag, "_done"},  int'(bus.done),     0);
  endtask

  initial begin
    // One entry per edge after reset; expectations are the post-edge outputs.
    tbl[0]  = mk(1,0,0, 1,8'h0A,0,0,0);
    tbl[1]  = mk(0,0,0, 1,8'h0A,0,0,0);
    tbl[2]  = mk(0,0,0, 1,8'h0A,0,0,0);
    tbl[3]  = mk(0,0,0, 1,8'h0A,0,1,0);
    tbl[4]  = mk(0,0,0, 1,8'h0A,1,0,0);
    tbl[5]  = mk(0,0,0, 1,8'h0A,1,0,0);
    tbl[6]  = mk(0,0,0, 1,8'h0A,1,0,0);
    tbl[7]  = mk(0,0,0, 1,8'h0A,1,1,0);
    tbl[8]  = mk(0,0,0, 1,8'h0A,2,0,0);
    tbl[9]  = mk(0,0,0, 1,8'h0A,2,0,0);
    tbl[10] = mk(0,0,0, 1,8'h0A,2,0,0);
    tbl[11] = mk(0,0,0, 1,8'h0A,2,1,0);
    tbl[12] = mk(0,0,0, 2,8'h05,3,0,0);
    tbl[13] = mk(0,0,0, 2,8'h05,3,0,0);
    tbl[14] = mk(0,0,0, 2,8'h05,3,0,0);
    tbl[15] = mk(0,0,0, 2,8'h05,3,1,0);
    tbl[16] = mk(0,0,0, 2,8'h05,3,0,0);
    tbl[17] = mk(0,0,0, 2,8'h05,3,0,0);
    tbl[18] = mk(0,0,0, 2,8'h05,3,0,0);
    tbl[19] = mk(0,0,0, 2,8'h05,3,1,0);
    tbl[20] = mk(0,0,0, 3,8'h0F,3,0,1);
    tbl[21] = mk(0,0,0, 3,8'h0F,3,0,0);
    tbl[22] = mk(0,1,0, 0,8'h00,0,0,0);

    bus.start = 1'b0; bus.advance = 1'b0; bus.abort = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    for (int k = 0; k < 23; k++) begin
      cycle(tbl[k].s, tbl[k].a, tbl[k].ab);
      check("tbl_phase", int'(bus.phase),    tbl[k].ph);
      check("tbl_led",   int'(bus.led_code), tbl[k].led);
      check("tbl_step",  int'(bus.step_cnt), tbl[k].step);
      check("tbl_tick",  int'(bus.tick),     tbl[k].tk);
      check("tbl_busy",  int'(bus.busy),     int'(tbl[k].ph != 0));
      check("tbl_done",  int'(bus.done),     tbl[k].dn);
    end

    // Early advance one cycle into WAIT
    cycle(1'b1, 1'b0, 1'b0);
    run_until(2, 40);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check("early_adv_phase", int'(bus.phase), 3);
    check("early_adv_done",  int'(bus.done),  1);
    cycle(1'b0, 1'b1, 1'b0);
    check("early_adv_idle",  int'(bus.phase), 0);

    // Abort in COUNT at step_cnt=1, then abort together with start in IDLE
    cycle(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 40 && int'(bus.step_cnt) != 1; n++) cycle(1'b0, 1'b0, 1'b0);
    check("abort_pre_step", int'(bus.step_cnt), 1);
    cycle(1'b0, 1'b0, 1'b1);
    check("abort_phase", int'(bus.phase),    0);
    check("abort_step",  int'(bus.step_cnt), 0);
    cycle(1'b1, 1'b0, 1'b1);
    check("abort_start_idle", int'(bus.phase), 0);

    // start toggling while busy must not disturb COUNT timing
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) cycle(1'(i % 2), 1'b0, 1'b0);
    check("toggle_phase", int'(bus.phase),    2);
    check("toggle_step",  int'(bus.step_cnt), 3);
    cycle(1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges while in WAIT
    #3 reset = 1'b1;
    #1 check_all_zero("async_reset");
    #2 reset = 1'b0;
    model_reset();
    cycle(1'b0, 1'b0, 1'b0);
    check("no_pending_start", int'(bus.phase), 0);

    // DONE behaviour without advance
    cycle(1'b1, 1'b0, 1'b0);
    run_until(3, 60);
    check("done_entry_pulse", int'(bus.done), 1);
`ifdef PHASE_SEQ_AUTO_RESTART_EN
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      check("auto_restart_phase", int'(bus.phase), (i < 4) ? 3 : 1);
    end
    check("auto_restart_step", int'(bus.step_cnt), 0);
`else
    for (int i = 1; i <= 55; i++) cycle(1'b0, 1'b0, 1'b0);
    check("done_hold_phase", int'(bus.phase), 3);
`endif
    cycle(1'b0, 1'b0, 1'b1);
    check("final_abort_idle", int'(bus.phase), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(1, 0)), ($urandom_range(7, 0) == 0), ($urandom_range(31, 0) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
